pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Sequencing controller for the pipeline front end. It sits beside the IF/ID and ID/EX registers and decides each cycle whether the PC and IF/ID hold, whether a bubble enters ID/EX, and whether IF/ID is flushed. It covers three cases: load-use hazards, branch resolution waits and multiply/divide-unit (MDU) occupancy. It replaces per-hazard combinational stall logic with one state machine and a small scoreboard.

## Interface
- `MDU_LATENCY`, 4: cycles the MDU stays busy after an issue (≥1).
- `BR_TIMEOUT`, 8: maximum cycles in BR_WAIT before the branch wait is aborted (≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_ex_mem_read` in 1: instruction in ID/EX is a load.
- `id_ex_rt` in 5: destination register of that load.
- `if_id_instr` in 32: instruction word in IF/ID.
- `ex_branch_valid` in 1: one-cycle pulse; the branch in EX resolved this cycle.
- `ex_branch_taken` in 1: resolution outcome; qualified by `ex_branch_valid`.
- `hold_pc` out 1: PC does not update.
- `hold_if_id` out 1: IF/ID does not update.
- `bubble_sel` out 1: ID/EX loads control zeros (NOP).
- `flush_if_id` out 1: IF/ID loads NOP.
- `mdu_start` out 1: one-cycle pulse; a mult/div leaves ID this cycle.
- `mdu_busy` out 1: MDU counter nonzero.
- `br_timeout_err` out 1: sticky; a branch wait timed out.

## Operation
- **Decode.** Fields from `if_id_instr`: op = [31:26], rs = [25:21], rt = [20:16], funct = [5:0].
  - Branch: op 000100 or 000101.
  - MDU op: op 000000 with funct 011000–011011.
  - HI/LO read: op 000000 with funct 010000 or 010010.
- **States.** IDLE and BR_WAIT.
- **IDLE priority.** Highest first; exactly one action per cycle:
  1. **Load-use.** Condition: `id_ex_mem_read` and `id_ex_rt` ≠ 0 and (`id_ex_rt` == rs or `id_ex_rt` == rt). Response: `hold_pc`, `hold_if_id` and `bubble_sel` = 1. Stay in IDLE.
  2. **MDU stall.** Condition: `mdu_busy` and (HI/LO read or MDU op) in IF/ID. Response: `hold_pc`, `hold_if_id` and `bubble_sel` = 1.
  3. **Branch.** Response: `hold_pc` = 1, `flush_if_id` = 1; the branch advances to ID/EX. Next state BR_WAIT, timeout counter cleared.
  4. **MDU issue.** Condition: MDU op with `mdu_busy` = 0. Response: `mdu_start` = 1; counter loads `MDU_LATENCY`.
  5. Otherwise all stall outputs are 0.
- **BR_WAIT.**
  - `ex_branch_valid` = 0: `hold_pc` = 1, `flush_if_id` = 1; counter increments.
  - `ex_branch_valid` = 1: `hold_pc` = 0, `flush_if_id` = `ex_branch_taken`. Go to IDLE.
  - Counter reaches `BR_TIMEOUT` − 1 with no valid: set `br_timeout_err`, all stall outputs 0, go to IDLE.
  - `ex_branch_valid` in IDLE is ignored.
- **MDU counter.**
  - Width $clog2(MDU_LATENCY+1).
  - Decrements by 1 each cycle while nonzero, saturating at 0.
  - `mdu_busy` = (counter ≠ 0).
  - Load takes precedence over decrement.
  - The counter runs in both states.
- **Errors.** `br_timeout_err` clears only on reset.

## Timing
- **Reset.** On assertion, state = IDLE, both counters = 0, `br_timeout_err` = 0. Every output is 0 during reset and in the first cycle after release, unless inputs raise an IDLE hazard.
- **Output paths.** Stall outputs and `mdu_start` are combinational from the current state, the counters and the inputs, so a hazard stalls in the same cycle it is seen. State and counters are registered.
- **Load-use.** Exactly one stall cycle. The next cycle ID/EX holds the bubble, so `id_ex_mem_read` = 0 and the condition does not re-fire.
- **Branch.**
  - Detection cycle plus N wait cycles, where N = cycles until `ex_branch_valid` arrives.
  - Valid arriving the cycle after detection gives exactly one BR_WAIT cycle.
  - The resolution cycle always releases `hold_pc`.
- **MDU.** Issue at cycle t: `mdu_busy` = 1 for cycles t+1 … t+MDU_LATENCY. A HI/LO read in IF/ID is released at cycle t+MDU_LATENCY+1.
- **Asynchronous reset mid-operation** (BR_WAIT or MDU busy): outputs drop to 0 immediately, with no flush pulse.

## Structure
- **Package `pipe_ctrl_pkg`:**
  - opcode/funct constants (BEQ, BNE, SPECIAL, MULT…DIVU, MFHI, MFLO);
  - state enum {IDLE, BR_WAIT};
  - a decode function returning is_branch, is_mdu, is_hilo.
- **Sub-module `mdu_scoreboard`.** Contains the load/decrement counter. Inputs: clock, reset, load. Outputs: busy, count. It is instantiated once.
- **Top level.** The top holds the FSM, the timeout counter and the output logic.

## Test plan
- **Load-use.** Load with rt = 5 in ID/EX; IF/ID `add $3,$5,$6`. Required: one cycle of `hold_pc`/`hold_if_id`/`bubble_sel` = 1, then 0. Repeat with rt = 0: no stall.
- **Branch taken.** `beq` in IF/ID; `ex_branch_valid`/`taken` = 1 on the 2nd following cycle. Required:
  - `hold_pc` = 1 for 2 cycles;
  - `flush_if_id` = 1 in the detection cycle, the wait cycle and the resolution cycle;
  - resolution cycle has `hold_pc` = 0; state returns to IDLE.
- **Branch not taken.** As above with taken = 0. Required: resolution cycle has `flush_if_id` = 0.
- **MDU.** MULT issued at t with `MDU_LATENCY` = 4; MFLO in IF/ID at t+1. Required: stall for cycles t+1 … t+4; release at t+5; one `mdu_start` pulse only at t.
- **Timeout.** `bne` with no `ex_branch_valid`, `BR_TIMEOUT` = 8. Required: `br_timeout_err` rises after 8 cycles, holds release and stay released; `rst_n` low clears the error.
- **Priority and reset.** Load-use and branch present together: load-use stall first, branch detected the next cycle. `rst_n` pulsed low mid-BR_WAIT: all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, FSM state type and instruction classifier for the
// pipeline front-end stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W = 6;
    localparam int unsigned FN_W = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;

    localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [FN_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [FN_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [FN_W-1:0] FN_DIVU  = 6'b011011;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic is_branch;
        logic is_mdu;
        logic is_hilo;
    } decode_t;

    // Classify the IF/ID instruction from its opcode and funct fields.
    function automatic decode_t decode_instr(input logic [OP_W-1:0] op,
                                             input logic [FN_W-1:0] funct);
        decode_t d;
        d.is_branch = (op == OP_BEQ) || (op == OP_BNE);
        d.is_mdu    = (op == OP_SPECIAL) &&
                      ((funct == FN_MULT) || (funct == FN_MULTU) ||
                       (funct == FN_DIV)  || (funct == FN_DIVU));
        d.is_hilo   = (op == OP_SPECIAL) &&
                      ((funct == FN_MFHI) || (funct == FN_MFLO));
        return d;
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Occupancy counter for the multiply/divide unit: loads the latency on issue
// and counts down to zero; busy while nonzero.
module mdu_scoreboard #(
    parameter int unsigned LATENCY = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    output logic                             busy,
    output logic [$clog2(LATENCY+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(LATENCY + 1);

    logic [CW-1:0] cnt;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy  = (cnt != '0);
    assign count = cnt;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Front-end sequencing controller: load-use stalls, branch resolution waits
// and MDU occupancy stalls from one FSM plus the MDU scoreboard.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned BR_TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [31:0] if_id_instr,
    input  logic        ex_branch_valid,
    input  logic        ex_branch_taken,
    output logic        hold_pc,
    output logic        hold_if_id,
    output logic        bubble_sel,
    output logic        flush_if_id,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        br_timeout_err
);

    localparam int unsigned BW = $clog2(BR_TIMEOUT);
    localparam int unsigned CW = $clog2(MDU_LATENCY + 1);

    state_t          state, state_n;
    logic [BW-1:0]   br_cnt, br_cnt_n;
    logic            err_n;
    logic [CW-1:0]   mdu_count;
    logic [REG_W-1:0] rs, rt;
    decode_t         dec;
    logic            load_use;
    logic            mdu_stall;
    logic            ctrl_unused;

    assign rs  = if_id_instr[25:21];
    assign rt  = if_id_instr[20:16];
    assign dec = decode_instr(if_id_instr[31:26], if_id_instr[5:0]);

    // Immediate, offset and shamt bits plus the raw count play no part here.
    assign ctrl_unused = ^{if_id_instr[15:6], mdu_count};

    // Hazard conditions seen in the current cycle.
    assign load_use  = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == rs) || (id_ex_rt == rt));
    assign mdu_stall = mdu_busy && (dec.is_hilo || dec.is_mdu);

    // MDU occupancy scoreboard, loaded whenever a mult/div leaves ID.
    mdu_scoreboard #(
        .LATENCY (MDU_LATENCY)
    ) u_mdu_scoreboard (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mdu_start),
        .busy  (mdu_busy),
        .count (mdu_count)
    );

    // State, branch-wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            br_cnt         <= '0;
            br_timeout_err <= 1'b0;
        end else begin
            state          <= state_n;
            br_cnt         <= br_cnt_n;
            br_timeout_err <= err_n;
        end
    end

    // Next-state and same-cycle stall outputs; one action per IDLE cycle.
    always_comb begin
        state_n     = state;
        br_cnt_n    = br_cnt;
        err_n       = br_timeout_err;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        bubble_sel  = 1'b0;
        flush_if_id = 1'b0;
        mdu_start   = 1'b0;

        unique case (state)
            IDLE: begin
                if (load_use || mdu_stall) begin
                    hold_pc    = 1'b1;
                    hold_if_id = 1'b1;
                    bubble_sel = 1'b1;
                end else if (dec.is_branch) begin
                    // Branch moves on to EX; fetch behind it is squashed.
                    hold_pc     = 1'b1;
                    flush_if_id = 1'b1;
                    state_n     = BR_WAIT;
                    br_cnt_n    = '0;
                end else if (dec.is_mdu) begin
                    mdu_start = 1'b1;
                end
            end
            BR_WAIT: begin
                if (ex_branch_valid) begin
                    flush_if_id = ex_branch_taken;
                    state_n     = IDLE;
                end else if (br_cnt == BW'(BR_TIMEOUT - 1)) begin
                    // Give up on the wait and let the pipeline run again.
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    hold_pc     = 1'b1;
                    flush_if_id = 1'b1;
                    br_cnt_n    = br_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

    logic        clk;
    logic        rst_n;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [31:0] if_id_instr;
    logic        ex_branch_valid;
    logic        ex_branch_taken;
    logic        hold_pc;
    logic        hold_if_id;
    logic        bubble_sel;
    logic        flush_if_id;
    logic        mdu_start;
    logic        mdu_busy;
    logic        br_timeout_err;

    // {hold_pc, hold_if_id, bubble_sel, flush_if_id, mdu_start, mdu_busy, br_timeout_err}
    logic [6:0]  outs;
    assign outs = {hold_pc, hold_if_id, bubble_sel, flush_if_id,
                   mdu_start, mdu_busy, br_timeout_err};

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADD  = {6'd0, 5'd5, 5'd6, 5'd3, 5'd0, 6'b100000};
    localparam logic [31:0] I_BEQ  = {6'b000100, 5'd1, 5'd2, 16'd4};
    localparam logic [31:0] I_BNE  = {6'b000101, 5'd1, 5'd2, 16'd4};
    localparam logic [31:0] I_MULT = {6'd0, 5'd4, 5'd5, 10'd0, 6'b011000};
    localparam logic [31:0] I_MFLO = {6'd0, 10'd0, 5'd7, 5'd0, 6'b010010};

    pipeline_stall_controller #(
        .MDU_LATENCY (4),
        .BR_TIMEOUT  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rt        (id_ex_rt),
        .if_id_instr     (if_id_instr),
        .ex_branch_valid (ex_branch_valid),
        .ex_branch_taken (ex_branch_taken),
        .hold_pc         (hold_pc),
        .hold_if_id      (hold_if_id),
        .bubble_sel      (bubble_sel),
        .flush_if_id     (flush_if_id),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy),
        .br_timeout_err  (br_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        id_ex_mem_read  = 1'b0;
        id_ex_rt        = 5'd0;
        if_id_instr     = I_NOP;
        ex_branch_valid = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b0000000) $display("FAIL reset_hold: outs=%b expected=%b", outs, 7'b0000000);
        else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b0000000) $display("FAIL reset_release: outs=%b expected=%b", outs, 7'b0000000);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [6:0] exp [4];
        exp[0] = 7'b1110000;  // rt=5 matches rs: stall
        exp[1] = 7'b0000000;  // bubble in ID/EX: released
        exp[2] = 7'b0000000;  // load to $0: never a hazard
        exp[3] = 7'b1110000;  // rt=6 matches rt field: stall
        for (int i = 0; i < 4; i++) begin
            if_id_instr    = I_ADD;
            id_ex_mem_read = (i != 1);
            id_ex_rt       = (i == 0) ? 5'd5 : (i == 2) ? 5'd0 : (i == 3) ? 5'd6 : 5'd0;
            @(negedge clk);
            total_cnt++;
            if (outs !== exp[i]) $display("FAIL load_use[%0d]: outs=%b expected=%b", i, outs, exp[i]);
            else pass_cnt++;
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_branch(input logic taken);
        logic [6:0] exp [5];
        exp[0] = 7'b1001000;                 // detection
        exp[1] = 7'b1001000;                 // wait
        exp[2] = {3'b000, taken, 3'b000};    // resolution releases hold_pc
        exp[3] = 7'b0000000;                 // back in IDLE
        exp[4] = 7'b0000000;                 // valid in IDLE ignored
        for (int i = 0; i < 5; i++) begin
            if_id_instr     = (i == 0) ? I_BEQ : I_NOP;
            ex_branch_valid = (i == 2) || (i == 4);
            ex_branch_taken = ((i == 2) || (i == 4)) ? taken : 1'b0;
            @(negedge clk);
            total_cnt++;
            if (outs !== exp[i]) $display("FAIL branch_t%0d[%0d]: outs=%b expected=%b", taken, i, outs, exp[i]);
            else pass_cnt++;
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_mdu();
        logic [6:0] exp [7];
        exp[0] = 7'b0000100;  // t: issue
        exp[1] = 7'b1110010;  // t+1..t+4: MFLO stalled while busy
        exp[2] = 7'b1110010;
        exp[3] = 7'b1110010;
        exp[4] = 7'b1110010;
        exp[5] = 7'b0000000;  // t+5: released, not busy
        exp[6] = 7'b0000000;
        for (int i = 0; i < 7; i++) begin
            if_id_instr = (i == 0) ? I_MULT : (i <= 5) ? I_MFLO : I_NOP;
            @(negedge clk);
            total_cnt++;
            if (outs !== exp[i]) $display("FAIL mdu[%0d]: outs=%b expected=%b", i, outs, exp[i]);
            else pass_cnt++;
            next_cycle();
        end
        // Back-to-back MULT: second one stalls on the busy unit.
        if_id_instr = I_MULT;
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b0000100) $display("FAIL mdu_b2b_issue: outs=%b expected=%b", outs, 7'b0000100);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b1110010) $display("FAIL mdu_b2b_stall: outs=%b expected=%b", outs, 7'b1110010);
        else pass_cnt++;
        quiet_inputs();
        repeat (5) next_cycle();
    endtask

    task automatic test_timeout();
        logic [6:0] exp;
        for (int i = 0; i < 11; i++) begin
            if_id_instr = (i == 0) ? I_BNE : I_NOP;
            exp = (i <= 7) ? 7'b1001000 : (i == 8) ? 7'b0000000 : 7'b0000001;
            @(negedge clk);
            total_cnt++;
            if (outs !== exp) $display("FAIL timeout[%0d]: outs=%b expected=%b", i, outs, exp);
            else pass_cnt++;
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (outs !== 7'b0000000) $display("FAIL timeout_clear: outs=%b expected=%b", outs, 7'b0000000);
        else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_priority();
        logic [6:0] exp [3];
        exp[0] = 7'b1110000;  // load-use wins over branch
        exp[1] = 7'b1001000;  // branch detected next cycle
        exp[2] = 7'b0001000;  // resolved taken
        for (int i = 0; i < 3; i++) begin
            if_id_instr     = (i <= 1) ? I_BEQ : I_NOP;
            id_ex_mem_read  = (i == 0);
            id_ex_rt        = (i == 0) ? 5'd1 : 5'd0;
            ex_branch_valid = (i == 2);
            ex_branch_taken = (i == 2);
            @(negedge clk);
            total_cnt++;
            if (outs !== exp[i]) $display("FAIL priority[%0d]: outs=%b expected=%b", i, outs, exp[i]);
            else pass_cnt++;
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp [3];
        exp[0] = 7'b0000100;  // MULT issue
        exp[1] = 7'b1001010;  // branch detect while MDU busy
        exp[2] = 7'b1001010;  // BR_WAIT with MDU busy
        for (int i = 0; i < 3; i++) begin
            if_id_instr = (i == 0) ? I_MULT : (i == 1) ? I_BEQ : I_NOP;
            @(negedge clk);
            total_cnt++;
            if (outs !== exp[i]) $display("FAIL reset_mid_pre[%0d]: outs=%b expected=%b", i, outs, exp[i]);
            else pass_cnt++;
            if (i < 2) next_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (outs !== 7'b0000000) $display("FAIL reset_mid_drop: outs=%b expected=%b", outs, 7'b0000000);
        else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b0000000) $display("FAIL reset_mid_idle: outs=%b expected=%b", outs, 7'b0000000);
        else pass_cnt++;
        next_cycle();
        if_id_instr = I_BEQ;
        @(negedge clk);
        total_cnt++;
        if (outs !== 7'b1001000) $display("FAIL reset_mid_redetect: outs=%b expected=%b", outs, 7'b1001000);
        else pass_cnt++;
        quiet_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch(1'b1);
        test_branch(1'b0);
        test_mdu();
        test_timeout();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
